// File: rtl/fetch_sequencer.sv
//==============================================================================
// Module   : fetch_sequencer
// Brief    : MIPS instruction-fetch front end. Owns the PC, runs a req/ack
//            fetch from instruction memory, holds the fetched word for
//            decode/execute and forms the next PC from pcsrc/jump.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_sequencer #(
    // Must be word-aligned.
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_count;
    logic [31:0] w_pcplus4;
    logic [31:0] w_br_off;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_pc_nxt;
    logic        w_load_instr;
    logic        w_retire;

    // Next-PC candidates; all arithmetic wraps modulo 2^32.
    always_comb begin
        w_pcplus4 = r_pc + 32'd4;
        w_br_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        w_jmp_tgt = {w_pcplus4[31:28], r_instr[25:0], 2'b00};
        if (jump) begin
            w_pc_nxt = w_jmp_tgt;           // jump has priority over branch
        end else if (pcsrc) begin
            w_pc_nxt = w_pcplus4 + w_br_off;
        end else begin
            w_pc_nxt = w_pcplus4;
        end
    end

    // Next-state logic and per-state strobes; ack only counts in REQ and
    // exec_done/pcsrc/jump only count in VALID.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_instr = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    w_load_instr = 1'b1;
                    w_state_nxt  = S_VALID;
                end
            end
            S_VALID: begin
                if (exec_done) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, PC, held instruction and retire counter; reset wins over all.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_instr) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc    <= w_pc_nxt;
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Outputs decoded from state and held registers.
    always_comb begin
        imem_req    = (r_state == S_REQ);
        instr_valid = (r_state == S_VALID);
        imem_addr   = r_pc;
        pc          = r_pc;
        pcplus4     = w_pcplus4;
        instr       = r_instr;
        op          = r_instr[31:26];
        funct       = r_instr[5:0];
        instr_count = r_count;
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
//==============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer: vector table, hand
//            corner-case sequences and random transactions against a
//            transaction-level next-PC model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, instr_valid, exec_done, pcsrc, jump;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pcplus4, instr_count;
    logic [5:0]  op, funct;

    // Second instance with a high reset PC for the jump-region test.
    logic        d2_req, d2_ack, d2_valid, d2_exec, d2_pcsrc, d2_jump;
    logic [31:0] d2_addr, d2_rdata, d2_instr, d2_pc, d2_pcplus4, d2_count;
    logic [5:0]  d2_op, d2_funct;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid),
        .exec_done(exec_done), .pcsrc(pcsrc), .jump(jump),
        .pc(pc), .pcplus4(pcplus4), .instr_count(instr_count)
    );

    fetch_sequencer #(.RESET_PC(32'h4000_0000)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_ack(d2_ack), .imem_rdata(d2_rdata),
        .instr(d2_instr), .op(d2_op), .funct(d2_funct), .instr_valid(d2_valid),
        .exec_done(d2_exec), .pcsrc(d2_pcsrc), .jump(d2_jump),
        .pc(d2_pc), .pcplus4(d2_pcplus4), .instr_count(d2_count)
    );

    typedef struct {
        logic [31:0] rdata;
        int          dly;
        int          hold;
        logic        ps;
        logic        jp;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
        logic [31:0] exp_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One full fetch/execute transaction on dut, all checks at negedge.
    task automatic txn(input logic [31:0] rdata, input int dly, input int hold,
                       input logic ps, input logic jp, input logic [31:0] exp_addr,
                       input logic [31:0] exp_next, input logic [31:0] exp_cnt);
        int n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        chk("imem_addr", imem_addr, exp_addr);
        for (int i = 0; i < dly; i++) begin
            imem_ack  = 1'b0;
            exec_done = 1'($urandom);
            pcsrc     = 1'($urandom);
            jump      = 1'($urandom);
            @(negedge clk);
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_stable", imem_addr, exp_addr);
        end
        exec_done  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("valid", {30'd0, instr_valid, imem_req}, 32'd2);
        chk("instr", instr, rdata);
        chk("op_funct", {20'd0, op, funct}, {20'd0, rdata[31:26], rdata[5:0]});
        chk("pc_pcplus4", pcplus4, exp_addr + 32'd4);
        for (int i = 0; i < hold; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            pcsrc      = 1'($urandom);
            jump       = 1'($urandom);
            exec_done  = 1'b0;
            @(negedge clk);
            chk("hold_instr", instr, rdata);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_count", instr_count, exp_cnt - 32'd1);
        end
        imem_ack  = 1'b0;
        pcsrc     = ps;
        jump      = jp;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        pcsrc     = 1'b0;
        jump      = 1'b0;
        chk("post_req", {30'd0, instr_valid, imem_req}, 32'd1);
        chk("next_addr", imem_addr, exp_next);
        chk("count", instr_count, exp_cnt);
    endtask

    // Reference next-PC: signed word offset relative to pc+4, or pseudo-direct jump.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input logic ps, input logic jp);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (jp)      return {seq[31:28], w[25:0], 2'b00};
        else if (ps) return seq + 32'(off);
        else         return seq;
    endfunction

    vec_t vt[9];

    initial begin
        logic [31:0] mpc, mcnt, rd, nxt;
        logic        ps, jp;
        int          n;

        vt[0] = '{32'h2008_0005, 0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'd1};
        vt[1] = '{32'h0000_0020, 2, 1, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0008, 32'd2};
        vt[2] = '{32'h1109_0003, 0, 0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0018, 32'd3};
        vt[3] = '{32'h0800_0002, 1, 0, 1'b0, 1'b1, 32'h0000_0018, 32'h0000_0008, 32'd4};
        vt[4] = '{32'h1109_FFFF, 0, 0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0008, 32'd5};
        vt[5] = '{32'h1000_FFFD, 5, 3, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'd6};
        vt[6] = '{32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'd7};
        vt[7] = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'd8};
        vt[8] = '{32'h0C00_0010, 0, 0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0040, 32'd9};

        imem_ack = 0; imem_rdata = 0; exec_done = 0; pcsrc = 0; jump = 0;
        d2_ack = 0; d2_rdata = 0; d2_exec = 0; d2_pcsrc = 0; d2_jump = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_outputs", {30'd0, instr_valid, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_pc_d2", d2_pc, 32'h4000_0000);

        // High-region jump: both jump and pcsrc set, jump wins.
        @(negedge clk);
        chk("d2_req", {31'd0, d2_req}, 32'd1);
        chk("d2_addr", d2_addr, 32'h4000_0000);
        d2_ack = 1'b1; d2_rdata = 32'h0800_0011;
        @(negedge clk);
        d2_ack = 1'b0;
        chk("d2_valid_op", {25'd0, d2_valid, d2_op}, {25'd0, 1'b1, 6'h02});
        d2_exec = 1'b1; d2_jump = 1'b1; d2_pcsrc = 1'b1;
        @(negedge clk);
        d2_exec = 1'b0; d2_jump = 1'b0; d2_pcsrc = 1'b0;
        chk("d2_jump_addr", d2_addr, 32'h4000_0044);
        chk("d2_count", d2_count, 32'd1);

        // Vector table from a fresh reset; first entry acks on first REQ cycle.
        do_reset();
        foreach (vt[i]) begin
            if (i == 0) begin
                @(negedge clk);
                chk("first_addr", imem_addr, 32'd0);
            end
            txn(vt[i].rdata, vt[i].dly, vt[i].hold, vt[i].ps, vt[i].jp,
                vt[i].exp_addr, vt[i].exp_next, vt[i].exp_cnt);
        end
        chk("first_op", {26'd0, vt[0].rdata[31:26]}, 32'h08);

        // Reset during REQ (pc=0x40, count=9, instr non-zero).
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0; imem_ack = 1'b0;
        chk("rstreq_flags", {30'd0, instr_valid, imem_req}, 32'd0);
        chk("rstreq_pc", pc, 32'd0);
        chk("rstreq_cnt_instr", instr_count | instr, 32'd0);

        // Reach VALID with count 1, then reset mid-execute.
        txn(32'h2008_0005, 1, 0, 1'b0, 1'b0, 32'd0, 32'd4, 32'd1);
        n = 0;
        while (!imem_req && n < 8) begin @(negedge clk); n++; end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        reset = 1'b1; exec_done = 1'b1;
        @(negedge clk);
        reset = 1'b0; exec_done = 1'b0;
        chk("rstval_flags", {30'd0, instr_valid, imem_req}, 32'd0);
        chk("rstval_pc", pc, 32'd0);
        chk("rstval_count", instr_count, 32'd0);
        chk("rstval_instr", instr, 32'd0);

        // Random transactions against the model, continuing from reset.
        mpc = 32'd0; mcnt = 32'd0;
        for (int k = 0; k < 40; k++) begin
            rd   = $urandom;
            ps   = 1'($urandom);
            jp   = 1'($urandom_range(0, 3) == 0);
            nxt  = model_next(mpc, rd, ps, jp);
            mcnt = mcnt + 32'd1;
            txn(rd, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), ps, jp, mpc, nxt, mcnt);
            mpc  = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
